// File: rtl/core_config_pkg.sv
// core_config_pkg
// Shared core configuration: datapath widths, default ALU count and the
// commit-unit FSM state type, plus a small index helper used by
// round-robin style logic.
// No ports (package).
package core_config_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int N_ALU      = 4;

  // Commit FSM state, kept as plain encoded constants so legacy code that
  // compares against raw bit patterns keeps working.
  typedef logic [0:0] commit_state_t;
  localparam commit_state_t ST_RUN  = 1'b0;
  localparam commit_state_t ST_TRAP = 1'b1;

  // (idx + 1) mod n, for idx already in 0..n-1.
  function automatic int unsigned wrap_inc(input int unsigned idx,
                                           input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/commit_unit_if.sv
// commit_unit_if
// Bundle of the N ALU result ports seen by the commit unit.
//   alu_valid  : result pending on port i (held until cleared)
//   alu_res    : result data per port
//   alu_rd     : destination register per port
//   alu_error  : result is faulty
//   alu_req    : urgent-result priority request
//   alu_clear  : one-hot release pulse back to the ALU
// master = ALU bank side, slave = commit unit side.
interface commit_unit_if #(
  parameter int N_ALU      = core_config_pkg::N_ALU,
  parameter int XLEN       = core_config_pkg::XLEN,
  parameter int REG_ADDR_W = core_config_pkg::REG_ADDR_W
);

  logic [N_ALU-1:0]                 alu_valid;
  logic [N_ALU-1:0][XLEN-1:0]       alu_res;
  logic [N_ALU-1:0][REG_ADDR_W-1:0] alu_rd;
  logic [N_ALU-1:0]                 alu_error;
  logic [N_ALU-1:0]                 alu_req;
  logic [N_ALU-1:0]                 alu_clear;

  modport master (
    output alu_valid, alu_res, alu_rd, alu_error, alu_req,
    input  alu_clear
  );

  modport slave (
    input  alu_valid, alu_res, alu_rd, alu_error, alu_req,
    output alu_clear
  );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational N-way round-robin arbiter. Picks the first requester at or
// after ptr_i, wrapping around.
//   req_i   : request vector
//   ptr_i   : round-robin start position (0..N-1)
//   gnt_o   : one-hot grant (all zero when nothing requests)
//   idx_o   : encoded index of the granted requester
//   valid_o : at least one request present
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [IDX_W:0] pos;
  logic           found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    pos   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      // One extra bit so ptr + i cannot overflow before the wrap.
      pos = {1'b0, ptr_i} + (IDX_W + 1)'(i);
      if (pos >= (IDX_W + 1)'(N)) pos = pos - (IDX_W + 1)'(N);
      if (!found && req_i[pos[IDX_W-1:0]]) begin
        found                  = 1'b1;
        gnt_o[pos[IDX_W-1:0]]  = 1'b1;
        idx_o                  = pos[IDX_W-1:0];
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/commit_unit.sv
// commit_unit
// Commits one completed ALU result per cycle to the register file,
// releases the winning ALU, raises a precise exception on faulty results,
// supports flush and counts retired instructions.
//   clk, rst_n        : clock, asynchronous active-low reset
//   alu_bus           : ALU result ports (slave side), drives alu_clear
//   flush_i           : discard every pending result this cycle
//   exc_ack_i         : trap logic has taken the exception
//   rf_we_o/_waddr_o/_wdata_o   : register file write port
//   rd_release_o/_addr_o        : scoreboard release of the destination
//   exc_valid_o, exc_src_o      : exception pending and its source port
//   instret_o         : retired-instruction counter (wraps at 2^64)
module commit_unit #(
  parameter int N_ALU      = core_config_pkg::N_ALU,
  parameter int XLEN       = core_config_pkg::XLEN,
  parameter int REG_ADDR_W = core_config_pkg::REG_ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  commit_unit_if.slave               alu_bus,
  input  logic                       flush_i,
  input  logic                       exc_ack_i,
  output logic                       rf_we_o,
  output logic [REG_ADDR_W-1:0]      rf_waddr_o,
  output logic [XLEN-1:0]            rf_wdata_o,
  output logic                       rd_release_o,
  output logic [REG_ADDR_W-1:0]      rd_release_addr_o,
  output logic                       exc_valid_o,
  output logic [$clog2(N_ALU)-1:0]   exc_src_o,
  output logic [63:0]                instret_o
);

  import core_config_pkg::*;

  localparam int IDX_W = $clog2(N_ALU);

  commit_state_t         state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      exc_src_q, exc_src_d;
  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic                  rel_q, rel_d;
  logic [REG_ADDR_W-1:0] rel_addr_q, rel_addr_d;
  logic [63:0]           instret_q, instret_d;

  logic [N_ALU-1:0]      urgent;
  logic [N_ALU-1:0]      cand;
  logic [N_ALU-1:0]      gnt;
  logic [IDX_W-1:0]      win;
  logic                  any_cand;
  logic                  grant;
  logic                  win_err;
  logic [REG_ADDR_W-1:0] win_rd;
  logic [XLEN-1:0]       win_res;

  // Urgent results form the whole candidate set when any are present.
  assign urgent = alu_bus.alu_valid & alu_bus.alu_req;
  assign cand   = (|urgent) ? urgent : alu_bus.alu_valid;

  rr_arbiter #(
    .N     (N_ALU),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i   (cand),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt),
    .idx_o   (win),
    .valid_o (any_cand)
  );

  // Flush beats a grant; TRAP never grants.
  assign grant   = (state_q == ST_RUN) && !flush_i && any_cand;
  assign win_err = alu_bus.alu_error[win];
  assign win_rd  = alu_bus.alu_rd[win];
  assign win_res = alu_bus.alu_res[win];

  // Release pulse. Held low during reset so ALUs keep their results.
  always_comb begin
    alu_bus.alu_clear = '0;
    if (!rst_n)        alu_bus.alu_clear = '0;
    else if (flush_i)  alu_bus.alu_clear = alu_bus.alu_valid;
    else if (grant)    alu_bus.alu_clear = gnt;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    exc_src_d  = exc_src_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    rel_d      = 1'b0;
    rel_addr_d = rel_addr_q;
    instret_d  = instret_q;

    if (grant) begin
      ptr_d      = IDX_W'(wrap_inc(32'(win), N_ALU));
      rel_d      = 1'b1;
      rel_addr_d = win_rd;
      if (win_err) begin
        state_d   = ST_TRAP;
        exc_src_d = win;
      end else begin
        // x0 is hardwired: release it but never write it.
        we_d      = (win_rd != '0);
        waddr_d   = win_rd;
        wdata_d   = win_res;
        instret_d = instret_q + 64'd1;
      end
    end

    if ((state_q == ST_TRAP) && (flush_i || exc_ack_i)) state_d = ST_RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      ptr_q      <= '0;
      exc_src_q  <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      rel_q      <= 1'b0;
      rel_addr_q <= '0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      exc_src_q  <= exc_src_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      rel_q      <= rel_d;
      rel_addr_q <= rel_addr_d;
      instret_q  <= instret_d;
    end
  end

  assign rf_we_o           = we_q;
  assign rf_waddr_o        = waddr_q;
  assign rf_wdata_o        = wdata_q;
  assign rd_release_o      = rel_q;
  assign rd_release_addr_o = rel_addr_q;
  assign exc_valid_o       = (state_q == ST_TRAP);
  assign exc_src_o         = exc_src_q;
  assign instret_o         = instret_q;

endmodule

// File: tb/tb_commit_unit.sv
// tb_commit_unit
// Directed table of per-cycle vectors for commit_unit plus hand sequences
// for reset, single-result data and the x0 destination.
module tb_commit_unit;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        exc_ack_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        rd_release_o;
  logic [4:0]  rd_release_addr_o;
  logic        exc_valid_o;
  logic [1:0]  exc_src_o;
  logic [63:0] instret_o;

  int n_chk;
  int n_err;

  commit_unit_if #(.N_ALU(4), .XLEN(32), .REG_ADDR_W(5)) bus ();

  commit_unit #(.N_ALU(4), .XLEN(32), .REG_ADDR_W(5)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .alu_bus           (bus),
    .flush_i           (flush_i),
    .exc_ack_i         (exc_ack_i),
    .rf_we_o           (rf_we_o),
    .rf_waddr_o        (rf_waddr_o),
    .rf_wdata_o        (rf_wdata_o),
    .rd_release_o      (rd_release_o),
    .rd_release_addr_o (rd_release_addr_o),
    .exc_valid_o       (exc_valid_o),
    .exc_src_o         (exc_src_o),
    .instret_o         (instret_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  req;
    logic [3:0]  err;
    logic        flush;
    logic        ack;
    logic [3:0]  x_clear;
    logic        x_we;
    logic [4:0]  x_waddr;
    logic [31:0] x_wdata;
    logic        x_rel;
    logic [4:0]  x_reladdr;
    logic        x_exc;
    logic [1:0]  x_src;
    logic [63:0] x_instret;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(
    input logic [3:0] valid, input logic [3:0] req, input logic [3:0] err,
    input logic flush, input logic ack, input logic [3:0] clr,
    input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
    input logic rel, input logic [4:0] reladdr,
    input logic exc, input logic [1:0] src, input logic [63:0] instret);
    vec_t v;
    v.valid = valid; v.req = req; v.err = err; v.flush = flush; v.ack = ack;
    v.x_clear = clr; v.x_we = we; v.x_waddr = waddr; v.x_wdata = wdata;
    v.x_rel = rel; v.x_reladdr = reladdr; v.x_exc = exc; v.x_src = src;
    v.x_instret = instret;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Inputs applied now (just after a rising edge); release pulse checked
  // mid-cycle, registered outputs checked just after the next rising edge.
  task automatic run_row(input vec_t v, input int k);
    bus.alu_valid = v.valid;
    bus.alu_req   = v.req;
    bus.alu_error = v.err;
    flush_i       = v.flush;
    exc_ack_i     = v.ack;
    @(negedge clk);
    chk($sformatf("row%0d clear", k), 64'(bus.alu_clear), 64'(v.x_clear));
    @(posedge clk);
    #1;
    chk($sformatf("row%0d rf_we", k), 64'(rf_we_o), 64'(v.x_we));
    chk($sformatf("row%0d rd_release", k), 64'(rd_release_o), 64'(v.x_rel));
    chk($sformatf("row%0d exc_valid", k), 64'(exc_valid_o), 64'(v.x_exc));
    chk($sformatf("row%0d instret", k), instret_o, v.x_instret);
    if (v.x_we) begin
      chk($sformatf("row%0d waddr", k), 64'(rf_waddr_o), 64'(v.x_waddr));
      chk($sformatf("row%0d wdata", k), 64'(rf_wdata_o), 64'(v.x_wdata));
    end
    if (v.x_rel)
      chk($sformatf("row%0d rel_addr", k), 64'(rd_release_addr_o), 64'(v.x_reladdr));
    if (v.x_exc)
      chk($sformatf("row%0d exc_src", k), 64'(exc_src_o), 64'(v.x_src));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " clear"},    64'(bus.alu_clear),       64'h0);
    chk({tag, " rf_we"},    64'(rf_we_o),             64'h0);
    chk({tag, " waddr"},    64'(rf_waddr_o),          64'h0);
    chk({tag, " wdata"},    64'(rf_wdata_o),          64'h0);
    chk({tag, " rel"},      64'(rd_release_o),        64'h0);
    chk({tag, " rel_addr"}, 64'(rd_release_addr_o),   64'h0);
    chk({tag, " exc"},      64'(exc_valid_o),         64'h0);
    chk({tag, " exc_src"},  64'(exc_src_o),           64'h0);
    chk({tag, " instret"},  instret_o,                64'h0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    flush_i = 1'b0;
    exc_ack_i = 1'b0;
    bus.alu_valid = '0;
    bus.alu_req   = '0;
    bus.alu_error = '0;
    // Fixed port data: port i -> rd 8+i, result C0DE_000i.
    for (int i = 0; i < 4; i++) begin
      bus.alu_res[i] = 32'hC0DE_0000 + 32'(i);
      bus.alu_rd[i]  = 5'(8 + i);
    end

    //           valid  req    err   fl ak clr   we wa     wdata           rel ra     ex src inst
    tbl[0]  = mk(4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 5'd0,  32'h0,          0, 5'd0,  0, 0, 64'd0);
    tbl[1]  = mk(4'hF, 4'h0, 4'h0, 0, 0, 4'h1, 1, 5'd8,  32'hC0DE_0000,  1, 5'd8,  0, 0, 64'd1);
    tbl[2]  = mk(4'hF, 4'h0, 4'h0, 0, 0, 4'h2, 1, 5'd9,  32'hC0DE_0001,  1, 5'd9,  0, 0, 64'd2);
    tbl[3]  = mk(4'hF, 4'h0, 4'h0, 0, 0, 4'h4, 1, 5'd10, 32'hC0DE_0002,  1, 5'd10, 0, 0, 64'd3);
    tbl[4]  = mk(4'hF, 4'h0, 4'h0, 0, 0, 4'h8, 1, 5'd11, 32'hC0DE_0003,  1, 5'd11, 0, 0, 64'd4);
    tbl[5]  = mk(4'hF, 4'h0, 4'h0, 0, 0, 4'h1, 1, 5'd8,  32'hC0DE_0000,  1, 5'd8,  0, 0, 64'd5);
    tbl[6]  = mk(4'h4, 4'h0, 4'h0, 0, 0, 4'h4, 1, 5'd10, 32'hC0DE_0002,  1, 5'd10, 0, 0, 64'd6);
    tbl[7]  = mk(4'h5, 4'h4, 4'h0, 0, 0, 4'h4, 1, 5'd10, 32'hC0DE_0002,  1, 5'd10, 0, 0, 64'd7);
    tbl[8]  = mk(4'h1, 4'h0, 4'h0, 0, 0, 4'h1, 1, 5'd8,  32'hC0DE_0000,  1, 5'd8,  0, 0, 64'd8);
    tbl[9]  = mk(4'h2, 4'h8, 4'h0, 0, 0, 4'h2, 1, 5'd9,  32'hC0DE_0001,  1, 5'd9,  0, 0, 64'd9);
    tbl[10] = mk(4'h8, 4'h0, 4'h8, 0, 0, 4'h8, 0, 5'd0,  32'h0,          1, 5'd11, 1, 3, 64'd9);
    tbl[11] = mk(4'h3, 4'h0, 4'h0, 0, 0, 4'h0, 0, 5'd0,  32'h0,          0, 5'd0,  1, 3, 64'd9);
    tbl[12] = mk(4'h3, 4'h0, 4'h0, 0, 1, 4'h0, 0, 5'd0,  32'h0,          0, 5'd0,  0, 0, 64'd9);
    tbl[13] = mk(4'h3, 4'h0, 4'h0, 0, 0, 4'h1, 1, 5'd8,  32'hC0DE_0000,  1, 5'd8,  0, 0, 64'd10);
    tbl[14] = mk(4'h2, 4'h0, 4'h0, 0, 0, 4'h2, 1, 5'd9,  32'hC0DE_0001,  1, 5'd9,  0, 0, 64'd11);
    tbl[15] = mk(4'h3, 4'h0, 4'h0, 1, 0, 4'h3, 0, 5'd0,  32'h0,          0, 5'd0,  0, 0, 64'd11);
    tbl[16] = mk(4'h4, 4'h0, 4'h0, 0, 0, 4'h4, 1, 5'd10, 32'hC0DE_0002,  1, 5'd10, 0, 0, 64'd12);
    tbl[17] = mk(4'h9, 4'h1, 4'h0, 1, 0, 4'h9, 0, 5'd0,  32'h0,          0, 5'd0,  0, 0, 64'd12);
    tbl[18] = mk(4'h1, 4'h0, 4'h1, 0, 0, 4'h1, 0, 5'd0,  32'h0,          1, 5'd8,  1, 0, 64'd12);
    tbl[19] = mk(4'h6, 4'h0, 4'h0, 1, 0, 4'h6, 0, 5'd0,  32'h0,          0, 5'd0,  0, 0, 64'd12);
    tbl[20] = mk(4'h2, 4'h0, 4'h0, 0, 0, 4'h2, 1, 5'd9,  32'hC0DE_0001,  1, 5'd9,  0, 0, 64'd13);
    tbl[21] = mk(4'h8, 4'h0, 4'h8, 0, 0, 4'h8, 0, 5'd0,  32'h0,          1, 5'd11, 1, 3, 64'd13);
    tbl[22] = mk(4'h0, 4'h0, 4'h0, 0, 1, 4'h0, 0, 5'd0,  32'h0,          0, 5'd0,  0, 0, 64'd13);
    tbl[23] = mk(4'h4, 4'h0, 4'h0, 0, 0, 4'h4, 1, 5'd10, 32'hC0DE_0002,  1, 5'd10, 0, 0, 64'd14);

    // Reset state, checked while reset is held.
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 24; k++) run_row(tbl[k], k);

    // Reset in the middle of a commit: port 0 wins (pointer at 3).
    run_row(mk(4'h1, 4'h0, 4'h0, 0, 0, 4'h1, 1, 5'd8, 32'hC0DE_0000,
               1, 5'd8, 0, 0, 64'd15), 24);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    bus.alu_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single result on port 1.
    bus.alu_res[1] = 32'h0000_00AB;
    bus.alu_rd[1]  = 5'd5;
    run_row(mk(4'h2, 4'h0, 4'h0, 0, 0, 4'h2, 1, 5'd5, 32'h0000_00AB,
               1, 5'd5, 0, 0, 64'd1), 25);

    // Result to x0: released and retired but never written.
    bus.alu_res[2] = 32'hFFFF_FFFF;
    bus.alu_rd[2]  = 5'd0;
    run_row(mk(4'h4, 4'h0, 4'h0, 0, 0, 4'h4, 0, 5'd0, 32'h0,
               1, 5'd0, 0, 0, 64'd2), 26);

    run_row(mk(4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 5'd0, 32'h0,
               0, 5'd0, 0, 0, 64'd2), 27);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
